// File: rtl/crtc_vram_arbiter.sv
// crtc_vram_arbiter
//   Time-slot arbiter for the shared 64 KB video RAM. A free-running 2-bit
//   slot counter divides every character into four VRAM slots:
//
//   slot | use
//   -----+----------------------------------------------------------
//    0   | video byte 0 (or CPU access on a blank character, see below)
//    1   | video byte 1 (idle on a blank character)
//    2   | CPU access, when a new request is present
//    3   | idle / refresh, CRTC clock enable high
//
//   Video data returns one cycle after its address, so byte 0 lands at the
//   edge ending slot 1 and byte 1 at the edge ending slot 2, where the
//   16-bit word is published with VID_VALID during slot 3. A CPU access
//   granted in slot s completes at the edge ending slot s+1 and CPU_ACK is
//   high in slot s+2.
//
// Parameters
//   CPC_MAP   1: video byte address {MA[13:12], RA[2:0], MA[9:0], b}
//             0: linear address {1'b0, MA[13:0], b}
//
// Optional feature macro
//   VIDEO_SKIP_BLANK_EN  when defined, DE is sampled in slot 0; a character
//                        with DE low does no video fetch, hands slot 0 to
//                        the CPU and leaves slot 1 idle.
//
// Ports
//   CLOCK, nRESET            clock, synchronous active-low reset
//   CRTC_CE                  one-cycle CRTC clock enable (slot 3)
//   MA, RA, DE               CRTC address, row address, display enable
//   VID_DATA, VID_VALID      {byte1, byte0} of the last fetch, update strobe
//   CPU_REQ, CPU_WE          CPU request level and direction
//   CPU_ADDR, CPU_DI         CPU byte address and write data
//   CPU_DO, CPU_ACK          CPU read data and completion strobe
//   RAM_EN, RAM_WE           VRAM enable / write enable (combinational)
//   RAM_ADDR, RAM_DI         VRAM address / write data (combinational)
//   RAM_DO                   VRAM read data, one cycle after the address

module crtc_vram_arbiter #(
    parameter int CPC_MAP = 1
) (
    input  logic        CLOCK,
    input  logic        nRESET,
    output logic        CRTC_CE,
    input  logic [13:0] MA,
    input  logic [4:0]  RA,
    input  logic        DE,
    output logic [15:0] VID_DATA,
    output logic        VID_VALID,
    input  logic        CPU_REQ,
    input  logic        CPU_WE,
    input  logic [15:0] CPU_ADDR,
    input  logic [7:0]  CPU_DI,
    output logic [7:0]  CPU_DO,
    output logic        CPU_ACK,
    output logic        RAM_EN,
    output logic        RAM_WE,
    output logic [15:0] RAM_ADDR,
    output logic [7:0]  RAM_DI,
    input  logic [7:0]  RAM_DO
);

    logic [1:0]  sc;
    logic        skip_now;
    logic        skip_q;
    logic        video_slot;
    logic        cpu_slot;
    logic        new_req;
    logic        grant;
    logic        grant_q;
    logic        grant_we_q;
    logic [7:0]  byte0;
    logic [15:0] vaddr;

    // skip_now: this is slot 0 of a blank character. skip_q carries that
    // decision through slots 1..3 of the same character.
`ifdef VIDEO_SKIP_BLANK_EN
    assign skip_now = (sc == 2'd0) && !DE;

    always_ff @(posedge CLOCK) begin
        if (!nRESET)
            skip_q <= 1'b0;
        else if (sc == 2'd0)
            skip_q <= !DE;
    end
`else
    logic unused_de;

    assign skip_now  = 1'b0;
    assign skip_q    = 1'b0;
    assign unused_de = DE;
`endif

    generate
        if (CPC_MAP != 0) begin : g_cpc
            logic unused_ra;
            assign unused_ra = ^RA[4:3];
            assign vaddr = {MA[13:12], RA[2:0], MA[9:0], sc[0]};
        end else begin : g_linear
            logic unused_ra;
            assign unused_ra = ^RA;
            assign vaddr = {1'b0, MA, sc[0]};
        end
    endgenerate

    // A request still high during its own ACK cycle is the one just served.
    assign new_req    = CPU_REQ && !CPU_ACK;
    assign cpu_slot   = (sc == 2'd2) || skip_now;
    assign grant      = nRESET && cpu_slot && new_req;
    assign video_slot = nRESET && (((sc == 2'd0) && !skip_now) ||
                                   ((sc == 2'd1) && !skip_q));

    // Video and CPU slots are disjoint, so at most one branch is live.
    always_comb begin
        RAM_EN   = 1'b0;
        RAM_WE   = 1'b0;
        RAM_ADDR = 16'h0000;
        RAM_DI   = 8'h00;
        if (video_slot) begin
            RAM_EN   = 1'b1;
            RAM_ADDR = vaddr;
        end else if (grant) begin
            RAM_EN   = 1'b1;
            RAM_WE   = CPU_WE;
            RAM_ADDR = CPU_ADDR;
            RAM_DI   = CPU_DI;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!nRESET) begin
            sc         <= 2'd0;
            CRTC_CE    <= 1'b0;
            VID_VALID  <= 1'b0;
            VID_DATA   <= 16'h0000;
            CPU_ACK    <= 1'b0;
            CPU_DO     <= 8'h00;
            grant_q    <= 1'b0;
            grant_we_q <= 1'b0;
            byte0      <= 8'h00;
        end else begin
            sc         <= sc + 2'd1;
            CRTC_CE    <= (sc == 2'd2);
            VID_VALID  <= (sc == 2'd2) && !skip_q;
            grant_q    <= grant;
            grant_we_q <= CPU_WE;
            CPU_ACK    <= grant_q;
            if (grant_q && !grant_we_q)
                CPU_DO <= RAM_DO;
            if ((sc == 2'd1) && !skip_q)
                byte0 <= RAM_DO;
            if ((sc == 2'd2) && !skip_q)
                VID_DATA <= {RAM_DO, byte0};
        end
    end

endmodule
